sys_array_cell_db: RTL and testbench

Second-generation weight-stationary processing element for the systolic array. It keeps a double-buffered weight: a shadow register loaded over a north-to-south shift chain while the active weight keeps computing, then committed with a swap strobe. The multiply-accumulate is valid-qualified, has an optional multiplier pipeline stage, and saturating accumulation with a sticky overflow flag. Cells are tiled in a 2-D grid: data and valid flow east, partial sums and weights flow south.

---
 rtl/sys_array_pkg.sv | 55 +++++
 rtl/sys_array_wbank.sv | 67 ++++++
 rtl/sys_array_cell_db.sv | 154 +++++++++++++++
 tb/tb_sys_array_cell_db.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types, default widths and the saturating adder for the systolic array cells.
package sys_array_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 8;
  localparam int unsigned W_WIDTH_DEF   = 8;
  localparam int unsigned ACC_WIDTH_DEF = 24;

  // Working width of sat_add; every ACC_WIDTH must stay strictly below it.
  localparam int unsigned SAT_MAX_W = 64;

  // Encoded as {active_valid, shadow_full}.
  typedef enum logic [1:0] {
    W_EMPTY         = 2'b00,
    W_SHADOW_ONLY   = 2'b01,
    W_ACTIVE        = 2'b10,
    W_ACTIVE_SHADOW = 2'b11
  } wbank_state_e;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Adds two sign-extended operands that each fit in 'width' bits. The result is either clamped
  // or wrapped to 'width' bits (returned sign-extended), and ovf flags a sum outside the range.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int unsigned          width,
                                       input logic                 saturate);
    sat_res_t                   res;
    logic signed [SAT_MAX_W:0]  s;
    logic signed [SAT_MAX_W:0]  one;
    logic signed [SAT_MAX_W:0]  maxv;
    logic signed [SAT_MAX_W:0]  minv;
    logic signed [SAT_MAX_W:0]  wrap;
    int unsigned                sh;
    s    = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
    one  = {{SAT_MAX_W{1'b0}}, 1'b1};
    maxv = (one <<< (width - 1)) - one;
    minv = ~maxv;
    sh   = SAT_MAX_W + 1 - width;
    // Drop the bits above 'width' and sign-extend back: two's-complement wrap.
    wrap = (s <<< sh) >>> sh;
    res.ovf = (s > maxv) || (s < minv);
    if (saturate && (s > maxv)) begin
      res.sum = maxv[SAT_MAX_W-1:0];
    end else if (saturate && (s < minv)) begin
      res.sum = minv[SAT_MAX_W-1:0];
    end else begin
      res.sum = wrap[SAT_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sys_array_wbank.sv
// Double-buffered weight bank: shadow register on the column shift chain, active register
// committed by a swap strobe, and the {active_valid, shadow_full} state machine.
module sys_array_wbank
  import sys_array_pkg::*;
#(
  parameter int unsigned W_WIDTH = W_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_w_shift_en,
  input  logic signed [W_WIDTH-1:0] i_w_in,
  input  logic                      i_w_swap,
  output logic signed [W_WIDTH-1:0] o_w_out,
  output logic                      o_w_swap_out,
  output logic signed [W_WIDTH-1:0] o_active_w,
  output logic                      o_active_valid
);

  wbank_state_e              r_state;
  logic signed [W_WIDTH-1:0] r_shadow;
  logic signed [W_WIDTH-1:0] r_active;
  logic                      r_swap_out;

  // Weight registers, swap wavefront delay and bank state in one block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= W_EMPTY;
      r_shadow   <= '0;
      r_active   <= '0;
      r_swap_out <= 1'b0;
    end else begin
      r_swap_out <= i_w_swap;
      // Active always takes the old shadow, so swap+shift in one cycle needs no special case.
      if (i_w_swap) begin
        r_active <= r_shadow;
      end
      if (i_w_shift_en) begin
        r_shadow <= i_w_in;
      end
      unique case (r_state)
        W_EMPTY: begin
          if (i_w_shift_en) r_state <= W_SHADOW_ONLY;
        end
        W_SHADOW_ONLY: begin
          if (i_w_swap && i_w_shift_en) r_state <= W_ACTIVE_SHADOW;
          else if (i_w_swap)            r_state <= W_ACTIVE;
        end
        W_ACTIVE: begin
          // A swap with an empty shadow commits "no weight".
          if (i_w_swap && i_w_shift_en) r_state <= W_SHADOW_ONLY;
          else if (i_w_swap)            r_state <= W_EMPTY;
          else if (i_w_shift_en)        r_state <= W_ACTIVE_SHADOW;
        end
        W_ACTIVE_SHADOW: begin
          if (i_w_swap && !i_w_shift_en) r_state <= W_ACTIVE;
        end
        default: r_state <= W_EMPTY;
      endcase
    end
  end

  assign o_w_out        = r_shadow;
  assign o_w_swap_out   = r_swap_out;
  assign o_active_w     = r_active;
  assign o_active_valid = r_state[1];

endmodule

// File: rtl/sys_array_cell_db.sv
// Weight-stationary systolic PE with a double-buffered weight and a valid-qualified,
// optionally pipelined, saturating multiply-accumulate.
module sys_array_cell_db
  import sys_array_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned SATURATE  = 1,
  parameter int unsigned PIPE_MULT = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic signed [IN_WIDTH-1:0]  out_data,
  input  logic signed [ACC_WIDTH-1:0] psum_in,
  output logic                        psum_out_valid,
  output logic signed [ACC_WIDTH-1:0] psum_out,
  input  logic                        w_shift_en,
  input  logic signed [W_WIDTH-1:0]   w_in,
  output logic signed [W_WIDTH-1:0]   w_out,
  input  logic                        w_swap,
  output logic                        w_swap_out,
  output logic                        ovf,
  output logic                        nw_err
);

  localparam int unsigned PW = IN_WIDTH + W_WIDTH;

  if (ACC_WIDTH < PW) begin : g_acc_too_narrow
    $error("ACC_WIDTH must be >= IN_WIDTH + W_WIDTH");
  end
  if (ACC_WIDTH >= SAT_MAX_W) begin : g_acc_too_wide
    $error("ACC_WIDTH must be below SAT_MAX_W");
  end

  logic signed [W_WIDTH-1:0] w_active;
  logic                      w_active_valid;

  sys_array_wbank #(
    .W_WIDTH (W_WIDTH)
  ) u_wbank (
    .clk            (clk),
    .reset          (reset),
    .i_w_shift_en   (w_shift_en),
    .i_w_in         (w_in),
    .i_w_swap       (w_swap),
    .o_w_out        (w_out),
    .o_w_swap_out   (w_swap_out),
    .o_active_w     (w_active),
    .o_active_valid (w_active_valid)
  );

  // Low PW bits of an unsigned product of sign-extended operands equal the signed product.
  logic [PW-1:0] w_in_ext;
  logic [PW-1:0] w_wt_ext;
  logic [PW-1:0] w_prod;
  assign w_in_ext = {{W_WIDTH{in_data[IN_WIDTH-1]}}, in_data};
  assign w_wt_ext = {{IN_WIDTH{w_active[W_WIDTH-1]}}, w_active};
  // With no committed weight the product is zero, so the psum bypasses unchanged.
  assign w_prod   = w_active_valid ? (w_in_ext * w_wt_ext) : '0;

  logic                 r_out_valid;
  logic [IN_WIDTH-1:0]  r_out_data;
  logic                 r_nw_err;

  // East-bound forwarding and the sticky missing-weight flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_nw_err    <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data <= in_data;
      end
      if (in_valid && !w_active_valid) begin
        r_nw_err <= 1'b1;
      end
    end
  end

  logic                 w_s2_valid;
  logic [PW-1:0]        w_s2_prod;
  logic [ACC_WIDTH-1:0] w_s2_psum;

  if (PIPE_MULT != 0) begin : g_pipe
    logic                 r_p_valid;
    logic [PW-1:0]        r_p_prod;
    logic [ACC_WIDTH-1:0] r_p_psum;

    // Product stage: weight is sampled here, so later swaps do not affect the add stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_p_valid <= 1'b0;
        r_p_prod  <= '0;
        r_p_psum  <= '0;
      end else begin
        r_p_valid <= in_valid;
        if (in_valid) begin
          r_p_prod <= w_prod;
          r_p_psum <= psum_in;
        end
      end
    end

    assign w_s2_valid = r_p_valid;
    assign w_s2_prod  = r_p_prod;
    assign w_s2_psum  = r_p_psum;
  end else begin : g_nopipe
    assign w_s2_valid = in_valid;
    assign w_s2_prod  = w_prod;
    assign w_s2_psum  = psum_in;
  end

  logic [SAT_MAX_W-1:0] w_add_a;
  logic [SAT_MAX_W-1:0] w_add_b;
  sat_res_t             w_sat;
  assign w_add_a = {{(SAT_MAX_W - ACC_WIDTH){w_s2_psum[ACC_WIDTH-1]}}, w_s2_psum};
  assign w_add_b = {{(SAT_MAX_W - PW){w_s2_prod[PW-1]}}, w_s2_prod};
  assign w_sat   = sat_add(w_add_a, w_add_b, ACC_WIDTH, SATURATE != 0);

  logic                 r_psum_valid;
  logic [ACC_WIDTH-1:0] r_psum;
  logic                 r_ovf;

  // Accumulate stage: psum register, its valid strobe and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psum_valid <= 1'b0;
      r_psum       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_psum_valid <= w_s2_valid;
      if (w_s2_valid) begin
        r_psum <= w_sat.sum[ACC_WIDTH-1:0];
        if (w_sat.ovf) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign psum_out_valid = r_psum_valid;
  assign psum_out       = r_psum;
  assign ovf            = r_ovf;
  assign nw_err         = r_nw_err;

endmodule

// File: tb/tb_sys_array_cell_db.sv
// Directed bench: default cell (combinational and pipelined multiply), 16-bit saturating and
// wrapping cells, and a 3-deep column sharing the weight shift chain and psum chain.
module tb_sys_array_cell_db;

  logic clk;
  logic reset;

  int n_cmp;
  int n_bad;

  // Group A: two default cells driven identically, PIPE_MULT 0 and 1.
  logic               a_in_valid, a_shift, a_swap;
  logic signed [7:0]  a_in_data, a_w_in;
  logic signed [23:0] a_psum_in;
  logic               d0_ov, d0_pv, d0_swo, d0_ovf, d0_nwe;
  logic               d1_ov, d1_pv, d1_swo, d1_ovf, d1_nwe;
  logic signed [7:0]  d0_od, d0_wo, d1_od, d1_wo;
  logic signed [23:0] d0_psum, d1_psum;

  // Group S: 16-bit accumulators, saturating and wrapping.
  logic               s_in_valid, s_shift, s_swap;
  logic signed [7:0]  s_in_data, s_w_in;
  logic signed [15:0] s_psum_in;
  logic               ss_ov, ss_pv, ss_swo, ss_ovf, ss_nwe;
  logic               sw_ov, sw_pv, sw_swo, sw_ovf, sw_nwe;
  logic signed [7:0]  ss_od, ss_wo, sw_od, sw_wo;
  logic signed [15:0] ss_psum, sw_psum;

  // Group C: column of three cells, index 0 is the top.
  logic               c_shift, c_swap;
  logic signed [7:0]  c_w_in;
  logic signed [23:0] c_psum_top;
  logic [2:0]         c_v;
  logic signed [7:0]  c_d   [3];
  logic [2:0]         c_ov, c_pv, c_swo, c_ovf, c_nwe;
  logic signed [7:0]  c_od  [3];
  logic signed [7:0]  c_wo  [3];
  logic signed [23:0] c_psum[3];

  sys_array_cell_db #(.PIPE_MULT(0)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data), .out_valid(d0_ov),
    .out_data(d0_od), .psum_in(a_psum_in), .psum_out_valid(d0_pv), .psum_out(d0_psum),
    .w_shift_en(a_shift), .w_in(a_w_in), .w_out(d0_wo), .w_swap(a_swap), .w_swap_out(d0_swo),
    .ovf(d0_ovf), .nw_err(d0_nwe));

  sys_array_cell_db #(.PIPE_MULT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data), .out_valid(d1_ov),
    .out_data(d1_od), .psum_in(a_psum_in), .psum_out_valid(d1_pv), .psum_out(d1_psum),
    .w_shift_en(a_shift), .w_in(a_w_in), .w_out(d1_wo), .w_swap(a_swap), .w_swap_out(d1_swo),
    .ovf(d1_ovf), .nw_err(d1_nwe));

  sys_array_cell_db #(.ACC_WIDTH(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data), .out_valid(ss_ov),
    .out_data(ss_od), .psum_in(s_psum_in), .psum_out_valid(ss_pv), .psum_out(ss_psum),
    .w_shift_en(s_shift), .w_in(s_w_in), .w_out(ss_wo), .w_swap(s_swap), .w_swap_out(ss_swo),
    .ovf(ss_ovf), .nw_err(ss_nwe));

  sys_array_cell_db #(.ACC_WIDTH(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data), .out_valid(sw_ov),
    .out_data(sw_od), .psum_in(s_psum_in), .psum_out_valid(sw_pv), .psum_out(sw_psum),
    .w_shift_en(s_shift), .w_in(s_w_in), .w_out(sw_wo), .w_swap(s_swap), .w_swap_out(sw_swo),
    .ovf(sw_ovf), .nw_err(sw_nwe));

  sys_array_cell_db u_c0 (
    .clk(clk), .reset(reset), .in_valid(c_v[0]), .in_data(c_d[0]), .out_valid(c_ov[0]),
    .out_data(c_od[0]), .psum_in(c_psum_top), .psum_out_valid(c_pv[0]), .psum_out(c_psum[0]),
    .w_shift_en(c_shift), .w_in(c_w_in), .w_out(c_wo[0]), .w_swap(c_swap),
    .w_swap_out(c_swo[0]), .ovf(c_ovf[0]), .nw_err(c_nwe[0]));

  sys_array_cell_db u_c1 (
    .clk(clk), .reset(reset), .in_valid(c_v[1]), .in_data(c_d[1]), .out_valid(c_ov[1]),
    .out_data(c_od[1]), .psum_in(c_psum[0]), .psum_out_valid(c_pv[1]), .psum_out(c_psum[1]),
    .w_shift_en(c_shift), .w_in(c_wo[0]), .w_out(c_wo[1]), .w_swap(c_swap),
    .w_swap_out(c_swo[1]), .ovf(c_ovf[1]), .nw_err(c_nwe[1]));

  sys_array_cell_db u_c2 (
    .clk(clk), .reset(reset), .in_valid(c_v[2]), .in_data(c_d[2]), .out_valid(c_ov[2]),
    .out_data(c_od[2]), .psum_in(c_psum[1]), .psum_out_valid(c_pv[2]), .psum_out(c_psum[2]),
    .w_shift_en(c_shift), .w_in(c_wo[1]), .w_out(c_wo[2]), .w_swap(c_swap),
    .w_swap_out(c_swo[2]), .ovf(c_ovf[2]), .nw_err(c_nwe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int vec [3][3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a_in_valid = 0; a_shift = 0; a_swap = 0; a_in_data = 0; a_w_in = 0; a_psum_in = 0;
    s_in_valid = 0; s_shift = 0; s_swap = 0; s_in_data = 0; s_w_in = 0; s_psum_in = 0;
    c_shift = 0; c_swap = 0; c_w_in = 0; c_psum_top = 0; c_v = '0;
    for (int r = 0; r < 3; r++) c_d[r] = 0;
    // Column beats: {top, mid, bottom} activations; weights will be top=3, mid=2, bottom=1.
    vec[0][0] = 1;  vec[0][1] = 1;  vec[0][2] = 1;
    vec[1][0] = 2;  vec[1][1] = -1; vec[1][2] = 5;
    vec[2][0] = -3; vec[2][1] = 4;  vec[2][2] = -7;

    #3;
    check_eq("rst_psum_valid", d0_pv, 0);
    check_eq("rst_psum", d0_psum, 0);
    check_eq("rst_out_valid", d1_ov, 0);
    check_eq("rst_flags", {d0_ovf, d0_nwe, d1_ovf, d1_nwe}, 0);
    check_eq("rst_w_out", d0_wo, 0);
    tick();
    reset = 1'b0;

    // No weight committed: bypass and nw_err.
    a_in_valid = 1; a_in_data = 5; a_psum_in = 7;
    tick();
    a_in_valid = 0;
    check_eq("nw_psum", d0_psum, 7);
    check_eq("nw_psum_valid", d0_pv, 1);
    check_eq("nw_err", d0_nwe, 1);
    check_eq("nw_ovf", d0_ovf, 0);
    check_eq("nw_pipe_not_yet", d1_pv, 0);
    tick();
    check_eq("nw_pipe_psum", d1_psum, 7);
    check_eq("nw_pipe_valid", d1_pv, 1);
    check_eq("idle_valid_low", d0_pv, 0);
    check_eq("idle_psum_hold", d0_psum, 7);

    // Shift 3, swap, then 100 + (-4)*3 = 88.
    a_shift = 1; a_w_in = 3;
    tick();
    a_shift = 0;
    check_eq("shadow_3", d0_wo, 3);
    a_swap = 1;
    tick();
    a_swap = 0;
    check_eq("swap_out_pulse", d0_swo, 1);
    a_in_valid = 1; a_in_data = -4; a_psum_in = 100;
    tick();
    a_in_valid = 0;
    check_eq("swap_out_clear", d0_swo, 0);
    check_eq("mac_88", d0_psum, 88);
    check_eq("mac_88_valid", d0_pv, 1);
    check_eq("fwd_data", d0_od, -4);
    check_eq("fwd_valid", d0_ov, 1);
    check_eq("pipe_88_early", d1_pv, 0);
    tick();
    check_eq("pipe_88", d1_psum, 88);
    check_eq("pipe_88_valid", d1_pv, 1);
    check_eq("fwd_valid_low", d0_ov, 0);
    check_eq("fwd_data_hold", d0_od, -4);

    // Swap to 9 in the same cycle as a beat: that beat still uses 3.
    a_shift = 1; a_w_in = 9;
    tick();
    a_shift = 0;
    a_swap = 1; a_in_valid = 1; a_in_data = 2; a_psum_in = 0;
    tick();
    a_swap = 0;
    check_eq("swap_beat_old_w", d0_psum, 6);
    check_eq("swap_out_beat", d1_swo, 1);
    tick();
    a_in_valid = 0;
    check_eq("next_beat_new_w", d0_psum, 18);
    check_eq("pipe_swap_beat", d1_psum, 6);
    check_eq("swap_out_off", d1_swo, 0);
    tick();
    check_eq("pipe_next_beat", d1_psum, 18);
    check_eq("nw_err_sticky", d1_nwe, 1);

    // 16-bit accumulators with weight 127.
    s_shift = 1; s_w_in = 127;
    tick();
    s_shift = 0; s_swap = 1;
    tick();
    s_swap = 0;
    s_in_valid = 1; s_in_data = 1; s_psum_in = 0;
    tick();
    check_eq("sat_small", ss_psum, 127);
    check_eq("sat_small_ovf", ss_ovf, 0);
    s_in_data = 127; s_psum_in = 16'sd32767;
    tick();
    check_eq("sat_pos", ss_psum, 32767);
    check_eq("sat_pos_ovf", ss_ovf, 1);
    check_eq("wrap_pos", sw_psum, -16640);
    check_eq("wrap_pos_ovf", sw_ovf, 1);
    s_in_data = -128; s_psum_in = -16'sd32768;
    tick();
    s_in_valid = 0;
    check_eq("sat_neg", ss_psum, -32768);
    check_eq("wrap_neg", sw_psum, 16512);

    // Column: shift 1,2,3 so bottom=1, mid=2, top=3.
    c_shift = 1;
    for (int k = 1; k <= 3; k++) begin
      c_w_in = 8'(k);
      tick();
    end
    c_shift = 0;
    check_eq("col_top_w", c_wo[0], 3);
    check_eq("col_mid_w", c_wo[1], 2);
    check_eq("col_bot_w", c_wo[2], 1);
    c_swap = 1;
    tick();
    c_swap = 0;
    // Skewed back-to-back stream; bottom emits beat c-2 after cycle c.
    for (int c = 0; c < 6; c++) begin
      for (int r = 0; r < 3; r++) begin
        if ((c - r >= 0) && (c - r < 3)) begin
          c_v[r] = 1'b1;
          c_d[r] = 8'(vec[c-r][r]);
        end else begin
          c_v[r] = 1'b0;
        end
      end
      tick();
      if (c >= 2 && c < 5) begin
        check_eq("col_valid", c_pv[2], 1);
        check_eq("col_sum", c_psum[2],
                 3 * vec[c-2][0] + 2 * vec[c-2][1] + vec[c-2][2]);
      end else if (c == 5) begin
        check_eq("col_drain", c_pv[2], 0);
      end
    end
    c_v = '0;
    check_eq("col_no_nw_err", c_nwe, 0);

    // Asynchronous reset between edges with a pipelined beat in flight.
    a_in_valid = 1; a_in_data = 1; a_psum_in = 0;
    tick();
    a_in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_pipe_valid", d1_pv, 0);
    check_eq("arst_pipe_psum", d1_psum, 0);
    check_eq("arst_d0_psum", d0_psum, 0);
    check_eq("arst_out_valid", d0_ov, 0);
    check_eq("arst_nw_err", d1_nwe, 0);
    check_eq("arst_w_out", d1_wo, 0);
    #1;
    reset = 1'b0;
    tick();
    check_eq("arst_no_pulse1", d1_pv, 0);
    tick();
    check_eq("arst_no_pulse2", d1_pv, 0);
    // Weight gone after reset: bypass again.
    a_in_valid = 1; a_in_data = 5; a_psum_in = 7;
    tick();
    a_in_valid = 0;
    check_eq("arst_bypass", d0_psum, 7);
    check_eq("arst_bypass_nw", d0_nwe, 1);
    tick();
    check_eq("arst_pipe_bypass", d1_psum, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
